multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Parametrised multicycle successor to the single-cycle ARM control unit.
- Sequences each instruction through an FSM: fetch, decode, execute, memory, writeback.
- Holds the NZCV flag register and gates every architectural write with the condition code.
- Drives the shared-memory multicycle datapath: PC, IR, register file, ALU, and the single instruction/data memory.

Parameters:
EXT_ALU, 0, 1 adds EOR and CMP decode; ALUControl widens from 2 to 3 bits
IDX_SUB, 1, 1 honours the U bit (Instr[23]=0 gives address subtract); 0 always adds

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
Instr  in  20  instruction bits [31:12] from IR
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
PCWrite  out  1  PC load enable
AdrSrc  out  1  memory address select: 0 PC, 1 ALU result
MemWrite  out  1  data memory write strobe
IRWrite  out  1  instruction register load
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  1  0 register A, 1 PC
ALUSrcB  out  2  00 register B, 01 ExtImm, 10 constant 4
ALUControl  out  2+EXT_ALU  00 ADD, 01 SUB, 10 AND, 11 ORR, 100 EOR
ImmSrc  out  2  equals Op
RegSrc  out  2  {Op==01, Op==10}
RegWrite  out  1  register file write strobe
Undef  out  1  one-cycle pulse in DECODE for an unsupported instruction

Behaviour:
- Reset and clocking:
  - Clock is clk; reset is rst, asynchronous and active-low.
  - While rst=0: state=FETCH, flags=0000, cond_q=0, and PCWrite, IRWrite, MemWrite, RegWrite, Undef are forced 0.
  - Assertion mid-instruction aborts it immediately; no partial write survives.
  - First rising edge after release executes FETCH.
- Field decode:
  - Op=Instr[27:26], Funct=Instr[25:20], I=Funct[5], cmd=Funct[4:1], S=Funct[0], L=Funct[0], cond=Instr[31:28].
- Condition evaluation:
  - CondEx is combinational from the flag register and cond.
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1; 1111 gives 0.
  - cond_q captures CondEx on the edge leaving DECODE.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR (Op=01) | EXECUTER (Op=00, I=0) | EXECUTEI (Op=00, I=1) | BRANCH (Op=10) | FETCH (unsupported).
  - MEMADR -> MEMRD (L=1) | MEMWR (L=0).
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER, EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Latency in cycles: data-processing 4, LDR 5, STR 4, B 3, unsupported 2.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 (ungated).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10; Undef=1 if unsupported.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=SUB if IDX_SUB & ~Instr[23], else ADD.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=cond_q.
  - MEMWR: AdrSrc=1, MemWrite=cond_q.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUControl from cmd.
  - EXECUTEI: as EXECUTER but ALUSrcB=01.
  - ALUWB: ResultSrc=00, RegWrite=cond_q & ~NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=cond_q.
- cmd decode:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - EXT_ALU=1 only: 0001 EOR; 1010 CMP (SUB, NoWrite=1, S forced 1).
  - Any other cmd, or Op=11, is unsupported.
- Flag update, at the edge leaving EXECUTER/EXECUTEI when cond_q & S:
  - N,Z load from ALUFlags[3:2].
  - C,V load only for ADD/SUB/CMP; AND/ORR/EOR keep C,V.
  - Flags never change in any other state.
- ImmSrc and RegSrc are combinational from Instr, valid in every state.
- Instr must be stable from DECODE to instruction end; the IR guarantees this.

Test Plan:
- Reset: hold rst=0 3 cycles mid-EXECUTER, release -> strobes 0 during reset; FETCH next cycle with IRWrite=1, PCWrite=1; flags 0000.
- ADD imm (Instr[31:12]=0xE2811) -> states F,D,EI,WB; RegWrite=1 in cycle 4 only; ALUSrcB=01 in cycle 3.
- ADDS setting Z (ALUFlags=0100 in EXECUTEI), then BEQ (cond 0000) -> PCWrite=1 in BRANCH.
- Same sequence with BNE -> PCWrite=0 in BRANCH.
- LDR L=1, U=0, IDX_SUB=1 -> 5 cycles; ALUControl=SUB in MEMADR; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB.
- STR with cond NE while Z=1 -> MemWrite=0 in MEMWR.
- EXT_ALU=1, CMP with ALUFlags=1001 -> RegWrite=0 in ALUWB; flags become 1001.
- EXT_ALU=0, cmd 1010 -> Undef=1 in DECODE; returns to FETCH; flags unchanged.
- cond=1111 -> no write strobes for the instruction.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Bundle of controller <-> multicycle datapath signals.
// ALUControl gains a bit when the extended ALU operations are enabled.
interface multicycle_controller_if #(
    parameter int EXT_ALU = 0
);
    logic [19:0]          Instr;
    logic [3:0]           ALUFlags;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1+EXT_ALU:0]   ALUControl;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic                 RegWrite;
    logic                 Undef;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite, Undef
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite, Undef
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer
// with NZCV flag register and condition-gated architectural writes.
module multicycle_controller #(
    parameter int EXT_ALU = 0,
    parameter int IDX_SUB = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    localparam int AW = 2 + EXT_ALU;
    localparam logic [AW-1:0] ALU_ADD = AW'(3'd0);
    localparam logic [AW-1:0] ALU_SUB = AW'(3'd1);
    localparam logic [AW-1:0] ALU_AND = AW'(3'd2);
    localparam logic [AW-1:0] ALU_ORR = AW'(3'd3);
    localparam logic [AW-1:0] ALU_EOR = AW'(3'd4);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    flags_q, flags_d;
    logic          cond_q, cond_d;

    // Instr carries bits [31:12], so instruction bit k sits at index k-12.
    logic [1:0]    op;
    logic [5:0]    funct;
    logic [3:0]    cmd;
    logic [3:0]    cond;
    logic          i_bit, s_bit, l_bit, u_bit;
    logic          unused_instr;

    assign op           = bus.Instr[15:14];
    assign funct        = bus.Instr[13:8];
    assign cond         = bus.Instr[19:16];
    assign u_bit        = bus.Instr[11];
    assign i_bit        = funct[5];
    assign cmd          = funct[4:1];
    assign s_bit        = funct[0];
    assign l_bit        = funct[0];
    assign unused_instr = ^{bus.Instr[10:9], bus.Instr[7:0]};

    function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = cy;
            4'b0011: cond_ex = ~cy;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = cy & ~z;
            4'b1001: cond_ex = ~cy | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    endfunction

    logic [AW-1:0] alu_op;
    logic          dp_ok, no_write, set_flags, cv_upd, supported;

    always_comb begin
        alu_op    = ALU_ADD;
        dp_ok     = 1'b1;
        no_write  = 1'b0;
        set_flags = s_bit;
        cv_upd    = 1'b0;
        case (cmd)
            4'b0100: begin alu_op = ALU_ADD; cv_upd = 1'b1; end
            4'b0010: begin alu_op = ALU_SUB; cv_upd = 1'b1; end
            4'b0000: alu_op = ALU_AND;
            4'b1100: alu_op = ALU_ORR;
            4'b0001: begin
                if (EXT_ALU != 0) alu_op = ALU_EOR;
                else              dp_ok  = 1'b0;
            end
            4'b1010: begin
                // CMP: subtract purely for flags, so it always sets them and never writes back
                if (EXT_ALU != 0) begin
                    alu_op    = ALU_SUB;
                    no_write  = 1'b1;
                    set_flags = 1'b1;
                    cv_upd    = 1'b1;
                end else begin
                    dp_ok = 1'b0;
                end
            end
            default: dp_ok = 1'b0;
        endcase
        case (op)
            2'b00:   supported = dp_ok;
            2'b01,
            2'b10:   supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        cond_d  = cond_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                cond_d = cond_ex(cond, flags_q);
                case (op)
                    2'b00:   state_d = !dp_ok ? S_FETCH : (i_bit ? S_EXECI : S_EXECR);
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = l_bit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI: begin
                state_d = S_ALUWB;
                // Logical ops leave carry and overflow untouched
                if (cond_q && set_flags) begin
                    flags_d[3:2] = bus.ALUFlags[3:2];
                    if (cv_upd) flags_d[1:0] = bus.ALUFlags[1:0];
                end
            end
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
        end
    end

    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = ALU_ADD;
        bus.RegWrite   = 1'b0;
        bus.Undef      = 1'b0;
        bus.ImmSrc     = op;
        bus.RegSrc     = {op == 2'b01, op == 2'b10};
        case (state_q)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            S_DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.Undef     = ~supported;
            end
            S_MEMADR: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = ((IDX_SUB != 0) && !u_bit) ? ALU_SUB : ALU_ADD;
            end
            S_MEMRD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = cond_q;
            end
            S_MEMWR: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = cond_q;
            end
            S_EXECR:  bus.ALUControl = alu_op;
            S_EXECI: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_op;
            end
            S_ALUWB:  bus.RegWrite = cond_q & ~no_write;
            S_BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = cond_q;
            end
            default: ;
        endcase
        // State already reads FETCH during reset, so its strobes must be suppressed here
        if (!rst) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.RegWrite = 1'b0;
            bus.Undef    = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: base (EXT_ALU=0) and extended (EXT_ALU=1) instances.
module tb_multicycle_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] instr = 20'h0;
    logic [3:0]  alu_flags = 4'h0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    multicycle_controller_if #(.EXT_ALU(0)) if0();
    multicycle_controller_if #(.EXT_ALU(1)) if1();

    assign if0.Instr    = instr;
    assign if0.ALUFlags = alu_flags;
    assign if1.Instr    = instr;
    assign if1.ALUFlags = alu_flags;

    multicycle_controller #(.EXT_ALU(0), .IDX_SUB(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    multicycle_controller #(.EXT_ALU(1), .IDX_SUB(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // {PCWrite, IRWrite, MemWrite, RegWrite, Undef}
    logic [4:0] strb0, strb1;
    // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
    logic [8:0] mux1;
    assign strb0 = {if0.PCWrite, if0.IRWrite, if0.MemWrite, if0.RegWrite, if0.Undef};
    assign strb1 = {if1.PCWrite, if1.IRWrite, if1.MemWrite, if1.RegWrite, if1.Undef};
    assign mux1  = {if1.AdrSrc, if1.ResultSrc, if1.ALUSrcA, if1.ALUSrcB, if1.ALUControl};

    localparam logic [8:0] M_FETCH = 9'b0_10_1_10_000;

    task automatic test_reset();
        rst = 1'b0; instr = 20'hE0911; alu_flags = 4'b0011;
        repeat (2) @(negedge clk);
        n_tests++; if (strb1 !== 5'b00000) begin n_fail++; $display("FAIL reset_strobes: got %b want %b", strb1, 5'b00000); end
        n_tests++; if (dut1.flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want %b", dut1.flags_q, 4'b0000); end
        rst = 1'b1; #1;
        n_tests++; if ({strb1, mux1} !== {5'b11000, M_FETCH}) begin n_fail++; $display("FAIL reset_fetch: got %b want %b", {strb1, mux1}, {5'b11000, M_FETCH}); end
        repeat (2) @(negedge clk);
        n_tests++; if (mux1 !== 9'b0_00_0_00_000) begin n_fail++; $display("FAIL exec_r_mux: got %b want %b", mux1, 9'b0); end
        rst = 1'b0; #1;
        n_tests++; if (strb1 !== 5'b00000) begin n_fail++; $display("FAIL abort_strobes: got %b want %b", strb1, 5'b00000); end
        repeat (3) @(negedge clk);
        n_tests++; if (strb1 !== 5'b00000) begin n_fail++; $display("FAIL abort_hold: got %b want %b", strb1, 5'b00000); end
        rst = 1'b1; #1;
        n_tests++; if (strb1 !== 5'b11000) begin n_fail++; $display("FAIL release_fetch: got %b want %b", strb1, 5'b11000); end
        n_tests++; if (dut1.flags_q !== 4'b0000) begin n_fail++; $display("FAIL abort_flags: got %b want %b", dut1.flags_q, 4'b0000); end
        @(negedge clk);
        n_tests++; if ({strb1, mux1} !== {5'b00000, M_FETCH}) begin n_fail++; $display("FAIL release_decode: got %b want %b", {strb1, mux1}, {5'b00000, M_FETCH}); end
        repeat (2) @(negedge clk);
        n_tests++; if (strb1 !== 5'b00010) begin n_fail++; $display("FAIL adds_reg_wb: got %b want %b", strb1, 5'b00010); end
        n_tests++; if (dut1.flags_q !== 4'b0011) begin n_fail++; $display("FAIL adds_reg_flags: got %b want %b", dut1.flags_q, 4'b0011); end
        @(negedge clk);
    endtask

    task automatic test_add_imm();
        instr = 20'hE2811; alu_flags = 4'hF; #1;
        n_tests++; if ({if1.ImmSrc, if1.RegSrc} !== 4'b0000) begin n_fail++; $display("FAIL add_immsrc: got %b want %b", {if1.ImmSrc, if1.RegSrc}, 4'b0000); end
        n_tests++; if ({strb1, mux1} !== {5'b11000, M_FETCH}) begin n_fail++; $display("FAIL add_fetch: got %b want %b", {strb1, mux1}, {5'b11000, M_FETCH}); end
        @(negedge clk);
        n_tests++; if ({strb1, mux1} !== {5'b00000, M_FETCH}) begin n_fail++; $display("FAIL add_decode: got %b want %b", {strb1, mux1}, {5'b00000, M_FETCH}); end
        @(negedge clk);
        n_tests++; if ({strb1, mux1} !== {5'b00000, 9'b0_00_0_01_000}) begin n_fail++; $display("FAIL add_execi: got %b want %b", {strb1, mux1}, {5'b00000, 9'b0_00_0_01_000}); end
        @(negedge clk);
        n_tests++; if ({strb1, mux1} !== {5'b00010, 9'b0_00_0_00_000}) begin n_fail++; $display("FAIL add_aluwb: got %b want %b", {strb1, mux1}, {5'b00010, 9'b0}); end
        n_tests++; if (dut1.flags_q !== 4'b0011) begin n_fail++; $display("FAIL add_nos_flags: got %b want %b", dut1.flags_q, 4'b0011); end
        @(negedge clk);
        n_tests++; if (strb1 !== 5'b11000) begin n_fail++; $display("FAIL add_latency: got %b want %b", strb1, 5'b11000); end
    endtask

    task automatic run_adds_z();
        instr = 20'hE2911; alu_flags = 4'b0100;
        repeat (4) @(negedge clk);
        n_tests++; if (dut1.flags_q !== 4'b0100) begin n_fail++; $display("FAIL adds_z_flags: got %b want %b", dut1.flags_q, 4'b0100); end
    endtask

    task automatic test_adds_beq();
        run_adds_z();
        instr = 20'h0A000; #1;
        n_tests++; if ({if1.ImmSrc, if1.RegSrc} !== 4'b1001) begin n_fail++; $display("FAIL b_immsrc: got %b want %b", {if1.ImmSrc, if1.RegSrc}, 4'b1001); end
        repeat (2) @(negedge clk);
        n_tests++; if ({strb1, mux1} !== {5'b10000, 9'b0_10_0_01_000}) begin n_fail++; $display("FAIL beq_branch: got %b want %b", {strb1, mux1}, {5'b10000, 9'b0_10_0_01_000}); end
        @(negedge clk);
        n_tests++; if (strb1 !== 5'b11000) begin n_fail++; $display("FAIL b_latency: got %b want %b", strb1, 5'b11000); end
    endtask

    task automatic test_bne();
        run_adds_z();
        instr = 20'h1A000;
        repeat (2) @(negedge clk);
        n_tests++; if (strb1 !== 5'b00000) begin n_fail++; $display("FAIL bne_branch: got %b want %b", strb1, 5'b00000); end
        @(negedge clk);
    endtask

    task automatic test_ldr();
        instr = 20'hE5112; #1;
        n_tests++; if ({if1.ImmSrc, if1.RegSrc} !== 4'b0110) begin n_fail++; $display("FAIL ldr_immsrc: got %b want %b", {if1.ImmSrc, if1.RegSrc}, 4'b0110); end
        repeat (2) @(negedge clk);
        n_tests++; if (mux1 !== 9'b0_00_0_01_001) begin n_fail++; $display("FAIL ldr_memadr: got %b want %b", mux1, 9'b0_00_0_01_001); end
        n_tests++; if (if0.ALUControl !== 2'b01) begin n_fail++; $display("FAIL ldr_memadr_base: got %b want %b", if0.ALUControl, 2'b01); end
        @(negedge clk);
        n_tests++; if ({strb1, mux1} !== {5'b00000, 9'b1_00_0_00_000}) begin n_fail++; $display("FAIL ldr_memrd: got %b want %b", {strb1, mux1}, {5'b00000, 9'b1_00_0_00_000}); end
        @(negedge clk);
        n_tests++; if ({strb1, mux1} !== {5'b00010, 9'b0_01_0_00_000}) begin n_fail++; $display("FAIL ldr_memwb: got %b want %b", {strb1, mux1}, {5'b00010, 9'b0_01_0_00_000}); end
        @(negedge clk);
        n_tests++; if (strb1 !== 5'b11000) begin n_fail++; $display("FAIL ldr_latency: got %b want %b", strb1, 5'b11000); end
    endtask

    task automatic test_str();
        instr = 20'h15800;
        repeat (2) @(negedge clk);
        n_tests++; if (mux1 !== 9'b0_00_0_01_000) begin n_fail++; $display("FAIL str_memadr_add: got %b want %b", mux1, 9'b0_00_0_01_000); end
        @(negedge clk);
        n_tests++; if ({strb1, mux1} !== {5'b00000, 9'b1_00_0_00_000}) begin n_fail++; $display("FAIL strne_memwr: got %b want %b", {strb1, mux1}, {5'b00000, 9'b1_00_0_00_000}); end
        @(negedge clk);
        instr = 20'hE5800;
        repeat (3) @(negedge clk);
        n_tests++; if (strb1 !== 5'b00100) begin n_fail++; $display("FAIL stral_memwr: got %b want %b", strb1, 5'b00100); end
        @(negedge clk);
        n_tests++; if (strb1 !== 5'b11000) begin n_fail++; $display("FAIL str_latency: got %b want %b", strb1, 5'b11000); end
    endtask

    task automatic test_cmp();
        instr = 20'hE1500; alu_flags = 4'b1001;
        repeat (2) @(negedge clk);
        n_tests++; if (mux1 !== 9'b0_00_0_00_001) begin n_fail++; $display("FAIL cmp_execr: got %b want %b", mux1, 9'b0_00_0_00_001); end
        @(negedge clk);
        n_tests++; if (strb1 !== 5'b00000) begin n_fail++; $display("FAIL cmp_aluwb: got %b want %b", strb1, 5'b00000); end
        n_tests++; if (dut1.flags_q !== 4'b1001) begin n_fail++; $display("FAIL cmp_flags: got %b want %b", dut1.flags_q, 4'b1001); end
        @(negedge clk);
    endtask

    task automatic test_eor();
        instr = 20'hE0300; alu_flags = 4'b0110;
        repeat (2) @(negedge clk);
        n_tests++; if (mux1 !== 9'b0_00_0_00_100) begin n_fail++; $display("FAIL eor_execr: got %b want %b", mux1, 9'b0_00_0_00_100); end
        @(negedge clk);
        n_tests++; if (strb1 !== 5'b00010) begin n_fail++; $display("FAIL eor_aluwb: got %b want %b", strb1, 5'b00010); end
        n_tests++; if (dut1.flags_q !== 4'b0101) begin n_fail++; $display("FAIL eor_flags_keep_cv: got %b want %b", dut1.flags_q, 4'b0101); end
        @(negedge clk);
    endtask

    task automatic test_undef();
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        instr = 20'hE2911; alu_flags = 4'b0100;
        repeat (4) @(negedge clk);
        instr = 20'hE1500; alu_flags = 4'b1111;
        @(negedge clk);
        n_tests++; if (strb0 !== 5'b00001) begin n_fail++; $display("FAIL undef_decode: got %b want %b", strb0, 5'b00001); end
        n_tests++; if (strb1 !== 5'b00000) begin n_fail++; $display("FAIL ext_cmp_no_undef: got %b want %b", strb1, 5'b00000); end
        @(negedge clk);
        n_tests++; if (strb0 !== 5'b11000) begin n_fail++; $display("FAIL undef_to_fetch: got %b want %b", strb0, 5'b11000); end
        repeat (2) @(negedge clk);
        n_tests++; if (dut0.flags_q !== 4'b0100) begin n_fail++; $display("FAIL undef_flags: got %b want %b", dut0.flags_q, 4'b0100); end
    endtask

    task automatic test_cond_nv();
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        instr = 20'hF2811; alu_flags = 4'b0000;
        repeat (3) @(negedge clk);
        n_tests++; if (strb1 !== 5'b00000) begin n_fail++; $display("FAIL nv_aluwb: got %b want %b", strb1, 5'b00000); end
        @(negedge clk);
        instr = 20'hF5800;
        repeat (3) @(negedge clk);
        n_tests++; if (strb1 !== 5'b00000) begin n_fail++; $display("FAIL nv_memwr: got %b want %b", strb1, 5'b00000); end
        @(negedge clk);
        instr = 20'hFA000;
        repeat (2) @(negedge clk);
        n_tests++; if (strb1 !== 5'b00000) begin n_fail++; $display("FAIL nv_branch: got %b want %b", strb1, 5'b00000); end
        @(negedge clk);
        n_tests++; if (strb1 !== 5'b11000) begin n_fail++; $display("FAIL nv_back_to_fetch: got %b want %b", strb1, 5'b11000); end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_adds_beq();
        test_bne();
        test_ldr();
        test_str();
        test_cmp();
        test_eor();
        test_undef();
        test_cond_nv();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end
endmodule
